// File: rtl/eth_tx_framer.sv
// eth_tx_framer: turns the 32-bit sample stream into raw Ethernet frames for the MAC FIFO
// transmit port. Each frame is a fixed 4-word header, then the latched number of payload
// words, then an optional checksum trailer word.
// Optional feature macro: STICK_TX_CHECKSUM_EN appends one trailer word holding the
// mod-2^32 sum of the frame's payload words.
module eth_tx_framer #(
    parameter logic [47:0] DST_MAC  = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC  = 48'h0250_C2A0_0001,
    parameter logic [15:0] ETH_TYPE = 16'h88B5,
    parameter int          MAX_LEN  = 256,
    parameter int          LEN_W    = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_enable,
    input  logic [LEN_W-1:0] i_payload_len,
    input  logic [31:0]      i_data,
    input  logic             i_vld,
    output logic             o_rdy,
    output logic [31:0]      o_tx_data,
    output logic             o_tx_vld,
    output logic             o_tx_sop,
    output logic             o_tx_eop,
    input  logic             i_tx_rdy,
    output logic [15:0]      o_frame_cnt,
    output logic             o_busy
);

`ifdef STICK_TX_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, PAY = 2'd2, TRL = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, PAY = 2'd2} state_t;
`endif

    localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);

    state_t           state_r, state_s;
    logic [1:0]       hdr_idx_r, hdr_idx_s;
    logic [LEN_W-1:0] pay_cnt_r, pay_cnt_s;
    logic [LEN_W-1:0] len_r, len_s;
    logic [LEN_W-1:0] len_clamp_s;
    logic [15:0]      seq_r, seq_s;
    logic [31:0]      data_r, data_s;
    logic             vld_r, vld_s;
    logic             sop_r, sop_s;
    logic             eop_r, eop_s;
    logic             busy_r;
    logic             load_ok_s;
    logic             accept_s;
    logic             last_pay_s;
`ifdef STICK_TX_CHECKSUM_EN
    logic [31:0]      sum_r, sum_s;

    // Running payload checksum, wrapping modulo 2^32.
    function automatic logic [31:0] sum32(input logic [31:0] acc, input logic [31:0] word);
        sum32 = acc + word;
    endfunction
`endif

    // Header word selected by index; W3 carries the current sequence number.
    function automatic logic [31:0] hdr_word(input logic [1:0] idx, input logic [15:0] seq);
        case (idx)
            2'd0:    hdr_word = DST_MAC[47:16];
            2'd1:    hdr_word = {DST_MAC[15:0], SRC_MAC[47:32]};
            2'd2:    hdr_word = SRC_MAC[31:0];
            2'd3:    hdr_word = {ETH_TYPE, seq};
            default: hdr_word = 32'd0;
        endcase
    endfunction

    // The output register may take a new word when empty or when its word leaves this cycle.
    assign load_ok_s  = !vld_r || i_tx_rdy;
    assign accept_s   = vld_r && i_tx_rdy;
    assign last_pay_s = (pay_cnt_r == (len_r - LEN_W'(1)));
    assign o_rdy      = (state_r == PAY) && load_ok_s;

    // Length to latch at frame start: zero becomes one, oversize clamps to MAX_LEN.
    always_comb begin
        len_clamp_s = i_payload_len;
        if (i_payload_len == {LEN_W{1'b0}}) begin
            len_clamp_s = LEN_W'(1);
        end else if (i_payload_len > MAX_LEN_W) begin
            len_clamp_s = MAX_LEN_W;
        end else begin
            len_clamp_s = i_payload_len;
        end
    end

    // Next-state and next output-register contents.
    always_comb begin
        state_s   = state_r;
        hdr_idx_s = hdr_idx_r;
        pay_cnt_s = pay_cnt_r;
        len_s     = len_r;
        data_s    = data_r;
        vld_s     = vld_r;
        sop_s     = sop_r;
        eop_s     = eop_r;
`ifdef STICK_TX_CHECKSUM_EN
        sum_s     = sum_r;
`endif
        // A word leaving without a replacement empties the register.
        if (accept_s) begin
            vld_s = 1'b0;
            sop_s = 1'b0;
            eop_s = 1'b0;
        end else begin
            vld_s = vld_r;
        end
        // The frame is counted once its eop word has been taken by the MAC.
        if (accept_s && eop_r) begin
            seq_s = seq_r + 16'd1;
        end else begin
            seq_s = seq_r;
        end
        case (state_r)
            IDLE: begin
                if (i_enable && i_vld) begin
                    state_s   = HDR;
                    hdr_idx_s = 2'd0;
                    pay_cnt_s = {LEN_W{1'b0}};
                    len_s     = len_clamp_s;
`ifdef STICK_TX_CHECKSUM_EN
                    sum_s     = 32'd0;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            HDR: begin
                if (load_ok_s) begin
                    data_s = hdr_word(hdr_idx_r, seq_r);
                    vld_s  = 1'b1;
                    sop_s  = (hdr_idx_r == 2'd0);
                    eop_s  = 1'b0;
                    if (hdr_idx_r == 2'd3) begin
                        state_s = PAY;
                    end else begin
                        hdr_idx_s = hdr_idx_r + 2'd1;
                    end
                end else begin
                    state_s = HDR;
                end
            end
            PAY: begin
                if (load_ok_s) begin
                    if (i_vld) begin
                        data_s = i_data;
                        vld_s  = 1'b1;
                        sop_s  = 1'b0;
`ifdef STICK_TX_CHECKSUM_EN
                        eop_s  = 1'b0;
                        sum_s  = sum32(sum_r, i_data);
`else
                        eop_s  = last_pay_s;
`endif
                        if (last_pay_s) begin
`ifdef STICK_TX_CHECKSUM_EN
                            state_s = TRL;
`else
                            state_s = IDLE;
`endif
                        end else begin
                            pay_cnt_s = pay_cnt_r + LEN_W'(1);
                        end
                    end else begin
                        // No fill words: the link simply goes idle until data returns.
                        vld_s = 1'b0;
                        sop_s = 1'b0;
                        eop_s = 1'b0;
                    end
                end else begin
                    state_s = PAY;
                end
            end
`ifdef STICK_TX_CHECKSUM_EN
            TRL: begin
                if (load_ok_s) begin
                    data_s  = sum_r;
                    vld_s   = 1'b1;
                    sop_s   = 1'b0;
                    eop_s   = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = TRL;
                end
            end
`endif
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counters and the registered MAC-side outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            hdr_idx_r <= 2'd0;
            pay_cnt_r <= {LEN_W{1'b0}};
            len_r     <= {LEN_W{1'b0}};
            seq_r     <= 16'd0;
            data_r    <= 32'd0;
            vld_r     <= 1'b0;
            sop_r     <= 1'b0;
            eop_r     <= 1'b0;
            busy_r    <= 1'b0;
`ifdef STICK_TX_CHECKSUM_EN
            sum_r     <= 32'd0;
`endif
        end else begin
            state_r   <= state_s;
            hdr_idx_r <= hdr_idx_s;
            pay_cnt_r <= pay_cnt_s;
            len_r     <= len_s;
            seq_r     <= seq_s;
            data_r    <= data_s;
            vld_r     <= vld_s;
            sop_r     <= sop_s;
            eop_r     <= eop_s;
            busy_r    <= (state_s != IDLE);
`ifdef STICK_TX_CHECKSUM_EN
            sum_r     <= sum_s;
`endif
        end
    end

    assign o_tx_data   = data_r;
    assign o_tx_vld    = vld_r;
    assign o_tx_sop    = sop_r;
    assign o_tx_eop    = eop_r;
    assign o_frame_cnt = seq_r;
    assign o_busy      = busy_r;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed testbench for eth_tx_framer: captures every word the MAC accepts and compares
// it with frames built from hand-derived header constants and the driven payload.
`timescale 1ns/1ps
module tb_eth_tx_framer;
    localparam int MAX_LEN = 256;
`ifdef STICK_TX_CHECKSUM_EN
    localparam int TRL_N = 1;
`else
    localparam int TRL_N = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_enable = 1'b0;
    logic [8:0]  i_payload_len = 9'd0;
    logic [31:0] i_data = 32'd0;
    logic        i_vld = 1'b0;
    logic        i_tx_rdy = 1'b1;
    logic        o_rdy, o_tx_vld, o_tx_sop, o_tx_eop, o_busy;
    logic [31:0] o_tx_data;
    logic [15:0] o_frame_cnt;

    eth_tx_framer dut (
        .clk(clk), .reset(reset), .i_enable(i_enable), .i_payload_len(i_payload_len),
        .i_data(i_data), .i_vld(i_vld), .o_rdy(o_rdy), .o_tx_data(o_tx_data),
        .o_tx_vld(o_tx_vld), .o_tx_sop(o_tx_sop), .o_tx_eop(o_tx_eop), .i_tx_rdy(i_tx_rdy),
        .o_frame_cnt(o_frame_cnt), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [33:0] mon_q[$];
    int          mon_cyc[$];
    logic [31:0] pay_mem[0:299];
    logic [33:0] exp_w[0:599];
    int          exp_n = 0;
    logic [15:0] exp_seq = 16'd0;
    logic        drv_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record {sop, eop, data} of every word that transfers at the coming rising edge.
    always @(negedge clk) begin
        if (!reset && o_tx_vld && i_tx_rdy) begin
            mon_q.push_back({o_tx_sop, o_tx_eop, o_tx_data});
            mon_cyc.push_back(cyc);
        end
    end

    task automatic clr();
        mon_q.delete();
        mon_cyc.delete();
        exp_n = 0;
        drv_err = 1'b0;
    endtask

    task automatic push_exp(input logic [33:0] w);
        exp_w[exp_n] = w;
        exp_n = exp_n + 1;
    endtask

    // Expected frame: fixed header, payload from pay_mem[base..], optional sum trailer.
    task automatic build_exp(input int len_eff, input int base);
        logic [31:0] s;
        s = 32'd0;
        push_exp({2'b10, 32'hFFFF_FFFF});
        push_exp({2'b00, 32'hFFFF_0250});
        push_exp({2'b00, 32'hC2A0_0001});
        push_exp({2'b00, 16'h88B5, exp_seq});
        for (int k = 0; k < len_eff; k++) begin
            s = s + pay_mem[base + k];
            push_exp({1'b0, (TRL_N == 0) && (k == len_eff - 1), pay_mem[base + k]});
        end
        if (TRL_N == 1) push_exp({2'b01, s});
        exp_seq = exp_seq + 16'd1;
    endtask

    // Offer pay_mem[start..start+cnt-1] one word at a time, each held until accepted.
    task automatic drive(input int start, input int cnt);
        int   guard;
        logic acc;
        for (int i = 0; i < cnt; i++) begin
            if (!drv_err) begin
                i_data = pay_mem[start + i];
                i_vld = 1'b1;
                acc = 1'b0;
                guard = 0;
                while (!acc && guard < 400) begin
                    @(negedge clk);
                    acc = o_rdy;
                    @(posedge clk);
                    #1;
                    guard++;
                end
                if (!acc) drv_err = 1'b1;
            end
        end
        i_vld = 1'b0;
    endtask

    task automatic wait_words(input int n);
        int guard;
        guard = 0;
        while (mon_q.size() < n && guard < 3000) begin
            @(posedge clk);
            guard++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_state();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({o_tx_data, o_tx_vld, o_tx_sop, o_tx_eop, o_rdy, o_busy, o_frame_cnt} !== 53'd0) begin
            bad++;
            $display("FAIL reset_state: data=%h vld=%b sop=%b eop=%b rdy=%b busy=%b cnt=%0d, want all 0",
                     o_tx_data, o_tx_vld, o_tx_sop, o_tx_eop, o_rdy, o_busy, o_frame_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int fl;
        clr();
        fl = 7 + TRL_N;
        pay_mem[0] = 32'h1111_1111; pay_mem[1] = 32'h2222_2222; pay_mem[2] = 32'h3333_3333;
        pay_mem[3] = 32'h4444_4444; pay_mem[4] = 32'h5555_5555; pay_mem[5] = 32'h6666_6666;
        build_exp(3, 0);
        build_exp(3, 3);
        i_payload_len = 9'd3;
        i_enable = 1'b1;
        drive(0, 6);
        wait_words(2 * fl);
        total++;
        if (drv_err !== 1'b0 || mon_q.size() !== 2 * fl) begin
            bad++;
            $display("FAIL b2b_count: got %0d words (drv_err=%b), want %0d", mon_q.size(), drv_err, 2 * fl);
        end
        for (int k = 0; k < exp_n && k < mon_q.size(); k++) begin
            total++;
            if (mon_q[k] !== exp_w[k]) begin
                bad++;
                $display("FAIL b2b_word%0d: got sop/eop/data=%h want %h", k, mon_q[k], exp_w[k]);
            end
        end
        if (mon_q.size() >= 2 * fl) begin
            total++;
            if (mon_q[0][33] !== 1'b1 || mon_q[6][32] !== (TRL_N == 0)) begin
                bad++;
                $display("FAIL b2b_flags: sop0=%b eop6=%b, want 1 %b", mon_q[0][33], mon_q[6][32], TRL_N == 0);
            end
            total++;
            if (mon_q[fl + 3][31:0] !== 32'h88B5_0001) begin
                bad++;
                $display("FAIL b2b_seq: second W3=%h want 88b50001", mon_q[fl + 3][31:0]);
            end
            for (int f = 0; f < 2; f++) begin
                for (int k = 1; k < fl; k++) begin
                    total++;
                    if (mon_cyc[f * fl + k] - mon_cyc[f * fl + k - 1] !== 1) begin
                        bad++;
                        $display("FAIL b2b_gap f%0d w%0d: spacing %0d cycles, want 1", f, k,
                                 mon_cyc[f * fl + k] - mon_cyc[f * fl + k - 1]);
                    end
                end
            end
        end
        total++;
        if (o_frame_cnt !== exp_seq || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_cnt: cnt=%0d busy=%b, want %0d 0", o_frame_cnt, o_busy, exp_seq);
        end
    endtask

    task automatic test_reset_mid();
        clr();
        i_payload_len = 9'd3;
        i_enable = 1'b1;
        i_data = 32'hC0C0_C0C0;
        i_vld = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        total++;
        if (o_busy !== 1'b1 || o_tx_vld !== 1'b1 || o_frame_cnt !== 16'd2) begin
            bad++;
            $display("FAIL rst_pre: busy=%b vld=%b cnt=%0d, want 1 1 2", o_busy, o_tx_vld, o_frame_cnt);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({o_tx_data, o_tx_vld, o_tx_sop, o_tx_eop, o_rdy, o_busy, o_frame_cnt} !== 53'd0) begin
            bad++;
            $display("FAIL rst_mid: data=%h vld=%b sop=%b eop=%b rdy=%b busy=%b cnt=%0d, want all 0",
                     o_tx_data, o_tx_vld, o_tx_sop, o_tx_eop, o_rdy, o_busy, o_frame_cnt);
        end
        i_vld = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        clr();
        exp_seq = 16'd0;
        pay_mem[0] = 32'hD1D1_D1D1;
        i_payload_len = 9'd1;
        build_exp(1, 0);
        drive(0, 1);
        wait_words(5 + TRL_N);
        total++;
        if (mon_q.size() !== 5 + TRL_N) begin
            bad++;
            $display("FAIL rst_after_count: got %0d words, want %0d", mon_q.size(), 5 + TRL_N);
        end else begin
            total++;
            if (mon_q[3][31:0] !== 32'h88B5_0000) begin
                bad++;
                $display("FAIL rst_after_w3: got %h want 88b50000", mon_q[3][31:0]);
            end
            for (int k = 0; k < exp_n; k++) begin
                total++;
                if (mon_q[k] !== exp_w[k]) begin
                    bad++;
                    $display("FAIL rst_after_word%0d: got %h want %h", k, mon_q[k], exp_w[k]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int   guard;
        logic seen;
        clr();
        pay_mem[0] = 32'hA1A1_A1A1; pay_mem[1] = 32'hA2A2_A2A2; pay_mem[2] = 32'hA3A3_A3A3;
        build_exp(3, 0);
        i_payload_len = 9'd3;
        fork
            drive(0, 3);
            begin
                guard = 0;
                seen = 1'b0;
                while (!seen && guard < 200) begin
                    @(negedge clk);
                    seen = o_tx_vld && i_tx_rdy && (o_tx_data == 32'hA1A1_A1A1);
                    guard++;
                end
                total++;
                if (!seen) begin
                    bad++;
                    $display("FAIL bp_start: payload word 1 not seen, got %b want 1", seen);
                end else begin
                    @(posedge clk);
                    #1;
                    i_tx_rdy = 1'b0;
                    for (int c = 0; c < 5; c++) begin
                        @(negedge clk);
                        total++;
                        if ({o_tx_data, o_tx_vld, o_rdy} !== {32'hA2A2_A2A2, 1'b1, 1'b0}) begin
                            bad++;
                            $display("FAIL bp_hold c%0d: data=%h vld=%b rdy=%b, want a2a2a2a2 1 0",
                                     c, o_tx_data, o_tx_vld, o_rdy);
                        end
                        @(posedge clk);
                        #1;
                    end
                    i_tx_rdy = 1'b1;
                end
            end
        join
        wait_words(7 + TRL_N);
        total++;
        if (mon_q.size() !== 7 + TRL_N) begin
            bad++;
            $display("FAIL bp_count: got %0d words, want %0d", mon_q.size(), 7 + TRL_N);
        end
        for (int k = 0; k < exp_n && k < mon_q.size(); k++) begin
            total++;
            if (mon_q[k] !== exp_w[k]) begin
                bad++;
                $display("FAIL bp_word%0d: got %h want %h", k, mon_q[k], exp_w[k]);
            end
        end
    endtask

    task automatic test_input_gap();
        clr();
        pay_mem[0] = 32'hB1B1_B1B1; pay_mem[1] = 32'hB2B2_B2B2;
        pay_mem[2] = 32'hB3B3_B3B3; pay_mem[3] = 32'hB4B4_B4B4;
        build_exp(4, 0);
        i_payload_len = 9'd4;
        drive(0, 2);
        @(negedge clk);
        total++;
        if (o_tx_vld !== 1'b1 || o_tx_data !== 32'hB2B2_B2B2) begin
            bad++;
            $display("FAIL gap_queued: vld=%b data=%h, want 1 b2b2b2b2", o_tx_vld, o_tx_data);
        end
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            total++;
            if (o_tx_vld !== 1'b0) begin
                bad++;
                $display("FAIL gap_idle c%0d: vld=%b want 0", c, o_tx_vld);
            end
        end
        @(posedge clk);
        #1;
        drive(2, 2);
        wait_words(8 + TRL_N);
        total++;
        if (mon_q.size() !== 8 + TRL_N) begin
            bad++;
            $display("FAIL gap_count: got %0d words, want %0d", mon_q.size(), 8 + TRL_N);
        end
        for (int k = 0; k < exp_n && k < mon_q.size(); k++) begin
            total++;
            if (mon_q[k] !== exp_w[k]) begin
                bad++;
                $display("FAIL gap_word%0d: got %h want %h", k, mon_q[k], exp_w[k]);
            end
        end
    endtask

    task automatic test_len_limits();
        // Zero length still carries one payload word.
        clr();
        pay_mem[0] = 32'hE0E0_E0E0;
        build_exp(1, 0);
        i_payload_len = 9'd0;
        drive(0, 1);
        wait_words(5 + TRL_N);
        total++;
        if (mon_q.size() !== 5 + TRL_N || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL len0_count: got %0d words busy=%b, want %0d 0", mon_q.size(), o_busy, 5 + TRL_N);
        end
        for (int k = 0; k < exp_n && k < mon_q.size(); k++) begin
            total++;
            if (mon_q[k] !== exp_w[k]) begin
                bad++;
                $display("FAIL len0_word%0d: got %h want %h", k, mon_q[k], exp_w[k]);
            end
        end
        // Oversize length is clamped to MAX_LEN words.
        clr();
        for (int k = 0; k < MAX_LEN; k++) pay_mem[k] = 32'h5A00_0000 + k;
        build_exp(MAX_LEN, 0);
        i_payload_len = 9'(MAX_LEN + 7);
        drive(0, MAX_LEN);
        wait_words(MAX_LEN + 4 + TRL_N);
        total++;
        if (drv_err !== 1'b0 || mon_q.size() !== MAX_LEN + 4 + TRL_N || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL lenmax_count: got %0d words busy=%b drv_err=%b, want %0d 0 0",
                     mon_q.size(), o_busy, drv_err, MAX_LEN + 4 + TRL_N);
        end
        for (int k = 0; k < exp_n && k < mon_q.size(); k++) begin
            total++;
            if (mon_q[k] !== exp_w[k]) begin
                bad++;
                $display("FAIL lenmax_word%0d: got %h want %h", k, mon_q[k], exp_w[k]);
            end
        end
        // Length and enable changes mid-frame do not affect the frame in flight.
        clr();
        pay_mem[0] = 32'hF1F1_F1F1; pay_mem[1] = 32'hF2F2_F2F2;
        build_exp(2, 0);
        i_payload_len = 9'd2;
        drive(0, 1);
        i_payload_len = 9'd5;
        i_enable = 1'b0;
        drive(1, 1);
        wait_words(6 + TRL_N);
        total++;
        if (mon_q.size() !== 6 + TRL_N || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL lenchg_count: got %0d words busy=%b, want %0d 0", mon_q.size(), o_busy, 6 + TRL_N);
        end
        for (int k = 0; k < exp_n && k < mon_q.size(); k++) begin
            total++;
            if (mon_q[k] !== exp_w[k]) begin
                bad++;
                $display("FAIL lenchg_word%0d: got %h want %h", k, mon_q[k], exp_w[k]);
            end
        end
        i_enable = 1'b1;
    endtask

    task automatic test_checksum();
        clr();
        pay_mem[0] = 32'h1111_1111; pay_mem[1] = 32'h2222_2222; pay_mem[2] = 32'h3333_3333;
        build_exp(3, 0);
        i_payload_len = 9'd3;
        drive(0, 3);
        wait_words(7 + TRL_N);
        total++;
        if (mon_q.size() !== 7 + TRL_N) begin
            bad++;
            $display("FAIL csum_count: got %0d words, want %0d", mon_q.size(), 7 + TRL_N);
        end else begin
`ifdef STICK_TX_CHECKSUM_EN
            total++;
            if (mon_q[6] !== {2'b00, 32'h3333_3333} || mon_q[7] !== {2'b01, 32'h6666_6666}) begin
                bad++;
                $display("FAIL csum_trailer: w7=%h w8=%h, want 033333333 166666666", mon_q[6], mon_q[7]);
            end
`else
            total++;
            if (mon_q[6] !== {2'b01, 32'h3333_3333}) begin
                bad++;
                $display("FAIL csum_none: w7=%h, want 133333333", mon_q[6]);
            end
`endif
        end
        total++;
        if (o_frame_cnt !== exp_seq) begin
            bad++;
            $display("FAIL csum_cnt: cnt=%0d want %0d", o_frame_cnt, exp_seq);
        end
    endtask

    initial begin
        test_reset_state();
        test_back_to_back();
        test_reset_mid();
        test_backpressure();
        test_input_gap();
        test_len_limits();
        test_checksum();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
